// File: rtl/collector_pkg.sv
// Shared types and default sizes for the output collector.
package collector_pkg;

  localparam int unsigned DataWDefault = 32;
  localparam int unsigned DepthDefault = 8;
  localparam int unsigned CntWDefault  = 16;

  // Capture window phases.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StCapture = 2'd2,
    StDrain   = 2'd3
  } collector_state_t;

endpackage

// File: rtl/out_collector_if.sv
// Control, source and reader signals of the output collector.
// The checksum signal exists only when COLLECTOR_CHECKSUM_EN is defined.
interface out_collector_if
  import collector_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned CNT_W  = CntWDefault
);

  logic              start;
  logic [CNT_W-1:0]  len;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_ready;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  captured;
  logic              overflow;
`ifdef COLLECTOR_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;

  // Collector side.
  modport slave (
    input  start, len, in_valid, in_data, rd_ready,
    output in_ready, rd_valid, rd_data, busy, done, captured, overflow, checksum
  );

  // Environment side: source, reader and controller.
  modport master (
    output start, len, in_valid, in_data, rd_ready,
    input  in_ready, rd_valid, rd_data, busy, done, captured, overflow, checksum
  );
`else
  // Collector side.
  modport slave (
    input  start, len, in_valid, in_data, rd_ready,
    output in_ready, rd_valid, rd_data, busy, done, captured, overflow
  );

  // Environment side: source, reader and controller.
  modport master (
    output start, len, in_valid, in_data, rd_ready,
    input  in_ready, rd_valid, rd_data, busy, done, captured, overflow
  );
`endif

endinterface

// File: rtl/collector_fifo.sv
// First-word fall-through FIFO. Pointers carry one extra wrap bit so full
// and empty are told apart by the MSB compare.
module collector_fifo
  import collector_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned DEPTH  = DepthDefault
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [DATA_W-1:0] head_o
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned PtrW = AW + 1;

  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push, do_pop;

  // Status decode and head read; head is forced to zero while empty.
  always_comb begin
    empty_o = (wr_ptr_q == rd_ptr_q);
    full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    head_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  // A push into a full FIFO is allowed when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset since empty masks the head.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/out_collector.sv
// Capture-window collector: arms on start, accepts len samples into a FIFO,
// flags refused samples, then drains to the reader before going idle.
// Optional feature macro: COLLECTOR_CHECKSUM_EN adds an XOR checksum output.
module out_collector
  import collector_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned DEPTH  = DepthDefault,
  parameter int unsigned CNT_W  = CntWDefault
) (
  input  logic           clk,
  input  logic           reset,
  out_collector_if.slave bus
);

  collector_state_t  state_q, state_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  captured_q, captured_d;
  logic              overflow_q, overflow_d;
  logic              done_q, done_d;
`ifdef COLLECTOR_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
`endif

  logic              fifo_full, fifo_empty, fifo_pop;
  logic [DATA_W-1:0] fifo_head;
  logic              in_ready, accept;

  collector_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (accept),
    .data_i  (bus.in_data),
    .pop_i   (fifo_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  // Source handshake: only an open window with free space takes samples.
  always_comb begin
    in_ready = ((state_q == StArmed) || (state_q == StCapture)) && !fifo_full;
    accept   = bus.in_valid && in_ready;
    fifo_pop = !fifo_empty && bus.rd_ready;
  end

  // Window sequencing, counters and flags.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    captured_d = captured_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
`ifdef COLLECTOR_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          captured_d = '0;
          overflow_d = 1'b0;
`ifdef COLLECTOR_CHECKSUM_EN
          csum_d     = '0;
`endif
          if (bus.len == '0) begin
            // Empty window closes at once.
            done_d = 1'b1;
          end else begin
            len_d   = bus.len;
            state_d = StArmed;
          end
        end
      end
      StArmed: begin
        if (bus.in_valid) state_d = StCapture;
      end
      StCapture: begin
        if (bus.in_valid && !in_ready) overflow_d = 1'b1;
      end
      StDrain: begin
        if (fifo_empty) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      // Saturate rather than wrap.
      captured_d = (captured_q == '1) ? captured_q : captured_q + CNT_W'(1);
`ifdef COLLECTOR_CHECKSUM_EN
      csum_d     = csum_q ^ bus.in_data;
`endif
      if (captured_d >= len_q) begin
        state_d = StDrain;
        done_d  = 1'b1;
      end
    end
  end

  // FSM and registered status; reset discards the window without a done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      len_q      <= '0;
      captured_q <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef COLLECTOR_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      captured_q <= captured_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
`ifdef COLLECTOR_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.rd_valid = !fifo_empty;
  assign bus.rd_data  = fifo_head;
  assign bus.busy     = (state_q == StArmed) || (state_q == StCapture);
  assign bus.done     = done_q;
  assign bus.captured = captured_q;
  assign bus.overflow = overflow_q;
`ifdef COLLECTOR_CHECKSUM_EN
  assign bus.checksum = csum_q;
`endif

endmodule

// File: doc/out_collector.md
OUT_COLLECTOR -- requirements
Module: out_collector

Interface
REQ-001 Parameter DATA_W, default 32, width of captured samples.
REQ-002 Parameter DEPTH, default 8, FIFO entries; power of two, at least 2.
REQ-003 Parameter CNT_W, default 16, width of the capture-length and sample counters.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse that arms a capture window.
REQ-007 len  input  CNT_W  number of samples to capture; sampled when start is accepted.
REQ-008 in_valid  input  1  source sample is valid this cycle.
REQ-009 in_data  input  DATA_W  source sample, e.g. a generated module's out port.
REQ-010 in_ready  output  1  collector accepts the sample this cycle.
REQ-011 rd_valid  output  1  FIFO head is valid for the reader.
REQ-012 rd_data  output  DATA_W  FIFO head sample.
REQ-013 rd_ready  input  1  reader pops the head this cycle.
REQ-014 busy  output  1  asserted in ARMED and CAPTURE.
REQ-015 done  output  1  one-cycle pulse when the window closes.
REQ-016 captured  output  CNT_W  number of samples accepted in the current or last window.
REQ-017 overflow  output  1  sticky; set when a sample is refused for lack of space.

Function
REQ-018 States: IDLE, ARMED, CAPTURE, DRAIN.
- IDLE->ARMED on start with len != 0.
- start with len == 0 pulses done and stays in IDLE.
REQ-019 ARMED->CAPTURE on the first in_valid; that sample is accepted in the same cycle if the FIFO is not full.
REQ-020 In CAPTURE, in_ready = !full.
- A sample is accepted on in_valid && in_ready; captured increments by 1.
REQ-021 When captured reaches len, the FSM goes to DRAIN in the cycle after the final accept and pulses done in that same cycle.
REQ-022 DRAIN->IDLE when the FIFO is empty. start is ignored outside IDLE.
REQ-023 in_valid && !in_ready in CAPTURE sets overflow; the sample is dropped and captured does not increment.
REQ-024 in_ready is 0 in IDLE, ARMED-without-space and DRAIN; in_valid in those states is ignored without setting overflow.
REQ-025 FIFO is first-word fall-through.
- rd_valid = !empty; rd_data = head.
- The pop takes effect on rd_valid && rd_ready.
REQ-026 Simultaneous push and pop when full: both succeed and the count is unchanged. When empty: the push only; the sample appears on rd_data the next cycle.
REQ-027 Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full and empty are decoded from the MSB-differing compare.
REQ-028 The captured counter saturates at all-ones and never wraps.
REQ-029 overflow and captured clear on an accepted start, not on window close.

Reset
REQ-030 On reset assertion, asynchronously:
- state=IDLE, FIFO empty.
- in_ready=0, rd_valid=0, rd_data=0.
- busy=0, done=0, captured=0, overflow=0.
REQ-031 Reset mid-capture discards FIFO contents; no done pulse is produced.

Configuration
REQ-032 With macro COLLECTOR_CHECKSUM_EN defined:
- An extra output checksum, width DATA_W, is present.
- checksum is the XOR of all samples accepted in the window.
- It clears on an accepted start and on reset.
- It is valid from the cycle done pulses.
REQ-033 Without COLLECTOR_CHECKSUM_EN the port and its logic are absent; all other behaviour is identical.

Structure
REQ-034 Package collector_pkg holds the state enum type collector_state_t and the default constants for DATA_W, DEPTH and CNT_W.
REQ-035 The FIFO is the sub-module collector_fifo (DATA_W, DEPTH; push/pop/full/empty/head); out_collector holds the FSM, counters and flags.

Verification
REQ-036 Basic capture:
- Stimulus: start, len=4; in_valid continuous with data 1,2,3,4; rd_ready=1.
- Response: rd_data 1,2,3,4 in order; done one cycle after the 4th accept; captured=4; overflow=0.
REQ-037 Overflow:
- Stimulus: DEPTH=8, start, len=10, rd_ready=0, 10 samples offered.
- Response: 8 accepted, then in_ready=0 and overflow=1; captured=8; state stays CAPTURE.
REQ-038 Drain with back-pressure:
- Stimulus: continue the previous scenario with rd_ready toggling every other cycle.
- Response: the 8 entries drain in order; after space frees and the 2 remaining samples are accepted, done pulses and the FSM returns to IDLE when empty.
REQ-039 Edge cases:
- start with len=0: done pulses immediately, busy stays 0.
- start during CAPTURE: ignored; captured is unaffected.
REQ-040 Reset mid-operation:
- Stimulus: reset asserted after 3 of 6 samples are accepted.
- Response: all outputs go to zero asynchronously, no done pulse; a new start then captures normally.
REQ-041 Checksum (COLLECTOR_CHECKSUM_EN defined):
- Stimulus: samples 0x0F, 0xF0, 0xFF.
- Response: checksum=0x00 when done pulses.
